// File: rtl/aes_pkg.sv
// Shared AES constants and GF(2^8) helpers for the key schedule and inverse cipher.
// S-box values are computed from the field inverse and affine map rather than stored.
package aes_pkg;

  localparam int NR = 10;

  function automatic logic [7:0] rcon(input logic [3:0] i);
    logic [7:0] r;
    case (i)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      r = gmul(r, r);
      if (i != 0) r = gmul(r, x);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl1(input logic [7:0] b);
    return {b[6:0], b[7]};
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv;
    logic [7:0] t;
    logic [7:0] s;
    inv = gf_inv(x);
    t = inv;
    s = inv;
    for (int k = 1; k <= 4; k++) begin
      t = rotl1(t);
      s = s ^ t;
    end
    return s ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    logic [7:0] t;
    logic [7:0] y;
    t = s;
    y = 8'h05;
    for (int k = 1; k <= 6; k++) begin
      t = rotl1(t);
      if (k == 1 || k == 3 || k == 6) y = y ^ t;
    end
    return gf_inv(y);
  endfunction

endpackage

// File: rtl/inv_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns unless this is the final round.
module inv_round
  import aes_pkg::*;
(
  input  logic [127:0] data_in,
  input  logic [127:0] key_in,
  input  logic         last,
  output logic [127:0] data_out
);

  logic [127:0] added;
  logic [127:0] mixed;

  // Byte k sits at [127-8k -: 8]; row r of column c is byte 4c+r.
  always_comb begin
    added = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        added[127-8*(4*c+r) -: 8] = inv_sbox(data_in[127-8*(4*((c+4-r)%4)+r) -: 8])
                                    ^ key_in[127-8*(4*c+r) -: 8];
      end
    end
  end

  always_comb begin
    logic [7:0] a0, a1, a2, a3;
    mixed = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = added[127-32*c -: 8];
      a1 = added[119-32*c -: 8];
      a2 = added[111-32*c -: 8];
      a3 = added[103-32*c -: 8];
      mixed[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      mixed[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      mixed[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      mixed[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
  end

  assign data_out = last ? added : mixed;

endmodule

// File: rtl/aes128_decrypt_iter.sv
// Iterative AES-128 decryption: expands and caches all round keys, then runs one
// inverse round per clock. A cached key set lets repeat-key blocks skip expansion.
module aes128_decrypt_iter
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         keep_key,
  input  logic [127:0] data_in,
  input  logic [127:0] key_in,
  output logic         ready,
  output logic         valid,
  output logic [127:0] data_out
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_EXPAND = 2'd1;
  localparam logic [1:0] S_ADDKEY = 2'd2;
  localparam logic [1:0] S_ROUND  = 2'd3;

  localparam logic [3:0] LAST_RK = 4'(NR);

  logic [1:0]   fsm;
  logic [3:0]   cnt;
  logic         key_valid;
  logic [127:0] state_q;
  logic [127:0] rk [0:NR];
  logic [127:0] rk_prev;
  logic [127:0] rk_next;
  logic [127:0] round_key;
  logic [127:0] round_out;
  logic [31:0]  temp;
  logic         use_cache;

  assign use_cache = keep_key && key_valid;
  assign ready     = (fsm == S_IDLE);

  // One key-schedule step: rk[cnt] from rk[cnt-1] with RotWord/SubWord on the last word.
  always_comb begin
    rk_prev = rk[cnt - 4'd1];
    temp    = {sbox(rk_prev[23:16]), sbox(rk_prev[15:8]), sbox(rk_prev[7:0]), sbox(rk_prev[31:24])}
              ^ {rcon(cnt), 24'h000000};
    rk_next[127:96] = rk_prev[127:96] ^ temp;
    rk_next[95:64]  = rk_prev[95:64]  ^ rk_next[127:96];
    rk_next[63:32]  = rk_prev[63:32]  ^ rk_next[95:64];
    rk_next[31:0]   = rk_prev[31:0]   ^ rk_next[63:32];
  end

  assign round_key = rk[cnt];

  inv_round u_inv_round (
    .data_in  (state_q),
    .key_in   (round_key),
    .last     (cnt == 4'd0),
    .data_out (round_out)
  );

  // The round-key file needs no reset: key_valid decides whether it may be reused.
  always_ff @(posedge clk) begin
    if (fsm == S_IDLE && start && !use_cache) begin
      rk[0] <= key_in;
    end else if (fsm == S_EXPAND) begin
      rk[cnt] <= rk_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm       <= S_IDLE;
      cnt       <= 4'd0;
      key_valid <= 1'b0;
      state_q   <= '0;
      valid     <= 1'b0;
      data_out  <= '0;
    end else begin
      valid <= 1'b0;
      case (fsm)
        S_IDLE: begin
          if (start) begin
            state_q <= data_in;
            if (use_cache) begin
              fsm <= S_ADDKEY;
            end else begin
              key_valid <= 1'b0;
              cnt       <= 4'd1;
              fsm       <= S_EXPAND;
            end
          end
        end
        S_EXPAND: begin
          if (cnt == LAST_RK) begin
            key_valid <= 1'b1;
            fsm       <= S_ADDKEY;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        S_ADDKEY: begin
          state_q <= state_q ^ rk[NR];
          cnt     <= LAST_RK - 4'd1;
          fsm     <= S_ROUND;
        end
        S_ROUND: begin
          state_q <= round_out;
          if (cnt == 4'd0) begin
            data_out <= round_out;
            valid    <= 1'b1;
            fsm      <= S_IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: fsm <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes128_decrypt_iter.sv
// Self-checking bench: FIPS-197 vectors plus random blocks whose ciphertext comes
// from a forward AES-128 model built on a log/antilog S-box table.
module tb_aes128_decrypt_iter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         keep_key;
  logic [127:0] data_in;
  logic [127:0] key_in;
  logic         ready;
  logic         valid;
  logic [127:0] data_out;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] sbox_t [256];

  localparam logic [127:0] B_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C_PT  = 128'h00112233445566778899aabbccddeeff;

  aes128_decrypt_iter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .keep_key (keep_key),
    .data_in  (data_in),
    .key_in   (key_in),
    .ready    (ready),
    .valid    (valid),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return (b << 1) ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Generator 3 walks every nonzero field element; inverses come from the log table.
  task automatic buildSbox();
    logic [7:0] expt [256];
    int         logt [256];
    logic [7:0] p;
    logic [7:0] inv;
    logic [7:0] cst;
    logic [7:0] s;
    cst = 8'h63;
    p = 8'h01;
    for (int i = 0; i < 255; i++) begin
      expt[i] = p;
      logt[p] = i;
      p = p ^ xt(p);
    end
    for (int x = 0; x < 256; x++) begin
      inv = (x == 0) ? 8'h00 : expt[(255 - logt[x]) % 255];
      for (int b = 0; b < 8; b++)
        s[b] = inv[b] ^ inv[(b+4)%8] ^ inv[(b+5)%8] ^ inv[(b+6)%8] ^ inv[(b+7)%8] ^ cst[b];
      sbox_t[x] = s;
    end
  endtask

  function automatic logic [127:0] ref_encrypt(input logic [127:0] pt, input logic [127:0] key);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]], sbox_t[tmp[31:24]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox_t[s[4*((i/4 + i%4) % 4) + i%4]];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (rnd < 10) begin
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rnd + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Drives a request just after an edge; returns one cycle later with inputs scrambled.
  task automatic applyStimulus(input logic [127:0] ct, input logic [127:0] key, input logic kk);
    checkOutput("ready before start", {127'b0, ready}, 128'd1);
    start = 1'b1; data_in = ct; key_in = key; keep_key = kk;
    @(posedge clk); #1;
    start = 1'b0; keep_key = 1'b0; data_in = rand128(); key_in = rand128();
  endtask

  task automatic waitForValid(input string tag, input int exp_lat, input logic [127:0] exp_pt);
    int n;
    n = 1;
    while (!valid && n <= 40) begin
      @(posedge clk); #1;
      if (!valid) n++;
    end
    checkOutput({tag, " latency"}, 128'(n), 128'(exp_lat));
    checkOutput({tag, " data"}, data_out, exp_pt);
    checkOutput({tag, " ready"}, {127'b0, ready}, 128'd1);
  endtask

  task automatic checkPulse(input string tag, input logic [127:0] exp_pt);
    @(posedge clk); #1;
    checkOutput({tag, " pulse"}, {127'b0, valid}, 128'd0);
    checkOutput({tag, " hold"}, data_out, exp_pt);
  endtask

  initial begin
    logic [127:0] pt, key, ct;
    int k;
    buildSbox();
    rst_n = 1'b0; start = 1'b0; keep_key = 1'b0; data_in = '0; key_in = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset ready", {127'b0, ready}, 128'd1);
    checkOutput("reset valid", {127'b0, valid}, 128'd0);
    checkOutput("reset data_out", data_out, 128'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] cache miss after reset, vector B");
    applyStimulus(B_CT, B_KEY, 1'b1);
    waitForValid("B miss", 21, B_PT);
    checkPulse("B miss", B_PT);

    $display("[TB] vector C.1 then cached reuse");
    applyStimulus(C_CT, C_KEY, 1'b0);
    waitForValid("C full", 21, C_PT);
    applyStimulus(C_CT, 128'd0, 1'b1);
    waitForValid("C cached", 11, C_PT);
    checkPulse("C cached", C_PT);

    $display("[TB] start while busy");
    applyStimulus(B_CT, B_KEY, 1'b0);
    k = 1;
    while (k <= 40) begin
      @(posedge clk); #1;
      if (valid) break;
      checkOutput("busy ready", {127'b0, ready}, 128'd0);
      k++;
      if (k == 3 || k == 15) begin
        start = 1'b1; data_in = rand128(); key_in = rand128();
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    checkOutput("busy latency", 128'(k), 128'd21);
    checkOutput("busy data", data_out, B_PT);
    repeat (3) checkPulse("busy", B_PT);

    $display("[TB] random blocks");
    for (int i = 0; i < 8; i++) begin
      key = rand128();
      pt  = rand128();
      ct  = ref_encrypt(pt, key);
      applyStimulus(ct, key, 1'b0);
      waitForValid($sformatf("rand%0d full", i), 21, pt);
      pt = rand128();
      ct = ref_encrypt(pt, key);
      applyStimulus(ct, rand128(), 1'b1);
      waitForValid($sformatf("rand%0d cached", i), 11, pt);
      checkPulse($sformatf("rand%0d", i), pt);
    end

    $display("[TB] reset in the middle of a block");
    applyStimulus(B_CT, B_KEY, 1'b0);
    repeat (13) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset valid", {127'b0, valid}, 128'd0);
    checkOutput("midreset data_out", data_out, 128'd0);
    checkOutput("midreset ready", {127'b0, ready}, 128'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("after reset valid", {127'b0, valid}, 128'd0);
    applyStimulus(B_CT, B_KEY, 1'b1);
    waitForValid("post reset", 21, B_PT);
    checkPulse("post reset", B_PT);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
